// File: rtl/skid_buffer_pkg.sv
// Shared types for the skid buffer slice: occupancy state encoding and the
// default payload width used by both the core buffer and its array wrapper.
package skid_buffer_pkg;

  localparam int unsigned SKID_DEFAULT_WIDTH = 32;

  // EMPTY: nothing held; BUSY: output register holds a beat;
  // FULL: output register and skid register both hold beats.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage : skid_buffer_pkg

// File: rtl/unpacked_skid_buffer.sv
// Array-payload front end for skid_buffer: element i of the unpacked array
// maps to bits [i*DATA_WIDTH +: DATA_WIDTH] of one wide skid buffer.
module unpacked_skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SKID_DEFAULT_WIDTH,
  parameter int unsigned IN_SIZE    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data  [IN_SIZE-1:0],
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data [IN_SIZE-1:0],
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [DATA_WIDTH*IN_SIZE-1:0] flat_in;
  logic [DATA_WIDTH*IN_SIZE-1:0] flat_out;

  // Pack the input array into one wide word.
  always_comb begin
    flat_in = '0;
    for (int unsigned i = 0; i < IN_SIZE; i++) begin
      flat_in[i*DATA_WIDTH +: DATA_WIDTH] = in_data[i];
    end
  end

  // Unpack the wide registered word back into the output array.
  always_comb begin
    for (int unsigned i = 0; i < IN_SIZE; i++) begin
      out_data[i] = flat_out[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH * IN_SIZE)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (flat_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (flat_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule : unpacked_skid_buffer

// File: rtl/skid_buffer.sv
// Two-entry elastic stage on a valid/ready stream. Both the forward path
// (out_valid/out_data) and the backward path (in_ready) come straight from
// flops, so out_ready never reaches in_ready combinationally.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SKID_DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  skid_state_t           state_q,     state_d;
  logic                  in_ready_q,  in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [DATA_WIDTH-1:0] skid_q,      skid_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next-state and registered-output logic; every register holds by default.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    skid_d      = skid_q;

    unique case (state_q)
      EMPTY: begin
        // in_ready is 0 only in the first cycle out of reset; it rises here.
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_fire) begin
          state_d     = BUSY;
          out_data_d  = in_data;
          out_valid_d = 1'b1;
        end
      end

      BUSY: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b1;
        if (in_fire && out_fire) begin
          out_data_d = in_data;
        end else if (in_fire && !out_fire) begin
          // Consumer stalled in the same cycle a beat arrived: park it in skid.
          state_d    = FULL;
          skid_d     = in_data;
          in_ready_d = 1'b0;
        end else if (!in_fire && out_fire) begin
          state_d     = EMPTY;
          out_valid_d = 1'b0;
        end
      end

      FULL: begin
        // in_ready_q is 0 here, so in_valid cannot fire and is ignored.
        if (out_ready) begin
          state_d    = BUSY;
          out_data_d = skid_q;
          in_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = EMPTY;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      skid_q      <= skid_d;
    end
  end

endmodule : skid_buffer
